// File: rtl/irq_source_conditioner.sv
// irq_source_conditioner
// Front-end for the interrupt controller. Each of the NUM_IRQ asynchronous
// lines is synchronized, optionally glitch-filtered, then normalized by
// polarity. It is then qualified as a level or an edge, gated by mask and
// enable, and latched into W1C pending bits. A one-cycle trigger pulse fires
// when a pending bit rises.
// Optional glitch filter: define IRQ_COND_DEBOUNCE_EN.
module irq_source_conditioner #(
  parameter int NUM_IRQ         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  output logic [NUM_IRQ-1:0] irq_trigger_o,
  output logic               irq_any_o
);

  localparam logic [31:0] ADDR_MODE = 32'd0;
  localparam logic [31:0] ADDR_POL  = 32'd1;
  localparam logic [31:0] ADDR_MASK = 32'd2;
  localparam logic [31:0] ADDR_PEND = 32'd3;
  localparam logic [31:0] ADDR_RAW  = 32'd4;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_param_check
    $error("irq_source_conditioner: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_p0;
  logic [NUM_IRQ-1:0] synced_p0;
  logic [NUM_IRQ-1:0] cond_p1;
  logic [NUM_IRQ-1:0] norm_p1;
  logic [NUM_IRQ-1:0] event_p1;
  logic [NUM_IRQ-1:0] set_p1;
  logic [NUM_IRQ-1:0] w1c_p1;
  logic [NUM_IRQ-1:0] pending_nxt_p1;
  logic [NUM_IRQ-1:0] prev_p2;
  logic [NUM_IRQ-1:0] pending_p2;
  logic [NUM_IRQ-1:0] trig_p2;
  logic               any_p2;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               apb_acc;
  logic               apb_wr;
  logic               addr_hit;
  logic               unused_pwdata;

  // ---- stage p0: metastability synchronizer ----
  // Shift each raw line through SYNC_STAGES flops; runs regardless of enable.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], irq_raw_i};
    end
  end

  assign synced_p0 = sync_p0[SYNC_STAGES-1];

  // ---- stage p1: conditioned line level ----
`ifdef IRQ_COND_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] dbnc_cnt_p1 [NUM_IRQ];

  // Accept a new synced level only after it has held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      cond_p1 <= '0;
      for (int i = 0; i < NUM_IRQ; i++) dbnc_cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (synced_p0[i] != cond_p1[i]) begin
          if (dbnc_cnt_p1[i] == CNT_LAST) begin
            cond_p1[i]     <= synced_p0[i];
            dbnc_cnt_p1[i] <= '0;
          end else begin
            dbnc_cnt_p1[i] <= dbnc_cnt_p1[i] + 1'b1;
          end
        end else begin
          dbnc_cnt_p1[i] <= '0;
        end
      end
    end
  end
`else
  assign cond_p1 = synced_p0;
`endif

  // Polarity folds active-low/falling into active-high/rising.
  assign norm_p1  = cond_p1 ^ pol_q;
  assign event_p1 = (mode_q & norm_p1 & ~prev_p2) | (~mode_q & norm_p1);
  assign set_p1   = event_p1 & mask_q & {NUM_IRQ{enable_i}};

  assign apb_acc  = psel_i & penable_i;
  assign apb_wr   = apb_acc & pwrite_i;
  assign addr_hit = (paddr_i <= ADDR_RAW);
  assign w1c_p1   = (apb_wr && paddr_i == ADDR_PEND) ? pwdata_i[NUM_IRQ-1:0] : '0;

  // A new event beats a same-cycle W1C, so an active level line stays pending.
  assign pending_nxt_p1 = (pending_p2 & ~w1c_p1) | set_p1;

  // Software-programmable line configuration.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= '0;
      pol_q  <= '0;
      mask_q <= '0;
    end else if (apb_wr) begin
      if (paddr_i == ADDR_MODE) mode_q <= pwdata_i[NUM_IRQ-1:0];
      if (paddr_i == ADDR_POL)  pol_q  <= pwdata_i[NUM_IRQ-1:0];
      if (paddr_i == ADDR_MASK) mask_q <= pwdata_i[NUM_IRQ-1:0];
    end
  end

  // ---- stage p2: pending latch and trigger pulse ----
  // prev tracks norm every cycle so edge detection stays valid across enable.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_p2    <= '0;
      pending_p2 <= '0;
      trig_p2    <= '0;
      any_p2     <= 1'b0;
    end else begin
      prev_p2    <= norm_p1;
      pending_p2 <= pending_nxt_p1;
      trig_p2    <= set_p1 & ~pending_p2;
      any_p2     <= |(pending_nxt_p1 & mask_q);
    end
  end

  assign irq_trigger_o = trig_p2;
  assign irq_any_o     = any_p2;

  // Zero-wait-state combinational read mux.
  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i) begin
      case (paddr_i)
        ADDR_MODE: prdata_o = 32'(mode_q);
        ADDR_POL:  prdata_o = 32'(pol_q);
        ADDR_MASK: prdata_o = 32'(mask_q);
        ADDR_PEND: prdata_o = 32'(pending_p2);
        ADDR_RAW:  prdata_o = 32'(cond_p1);
        default:   prdata_o = '0;
      endcase
    end
  end

  assign pready_o      = 1'b1;
  assign pslverr_o     = apb_acc & ~addr_hit;
  assign unused_pwdata = ^pwdata_i;

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Self-checking bench for irq_source_conditioner: a line-level behavioural
// model checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_irq_source_conditioner;
  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 8;
`ifdef IRQ_COND_DEBOUNCE_EN
  localparam int LAT = S + D + 1;
`else
  localparam int LAT = S + 1;
`endif
  localparam int HOLD = LAT + 2;

  logic         pclk = 1'b0;
  logic         rst, enable, psel, penable, pwrite;
  logic [31:0]  paddr, pwdata, prdata;
  logic         pready, pslverr;
  logic [N-1:0] irq_raw, irq_trig;
  logic         irq_any;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int trig_cnt [N] = '{default: 0};
  int trig_edge [N] = '{default: 0};

  irq_source_conditioner #(
    .NUM_IRQ(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .pclk_i(pclk), .rst_i(rst), .enable_i(enable),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr),
    .irq_raw_i(irq_raw), .irq_trigger_o(irq_trig), .irq_any_o(irq_any)
  );

  always #5 pclk = ~pclk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: line levels seen through a sample history
  logic [N-1:0] m_mode, m_pol, m_mask, m_pend, m_lastnorm, m_trig, m_cond;
  logic         m_any;
  logic [N-1:0] m_hist [$];
  int           m_dcnt [N];

  function automatic logic [N-1:0] m_level();
`ifdef IRQ_COND_DEBOUNCE_EN
    return m_cond;
`else
    return m_hist[0];
`endif
  endfunction

  function automatic void model_step();
    logic [N-1:0] synced, norm, active, setv, w1c, nxt;
    if (rst) begin
      m_mode = '0; m_pol = '0; m_mask = '0; m_pend = '0;
      m_lastnorm = '0; m_trig = '0; m_cond = '0; m_any = 1'b0;
      m_hist = {};
      for (int k = 0; k < S; k++) m_hist.push_back('0);
      for (int i = 0; i < N; i++) m_dcnt[i] = 0;
      return;
    end
    synced = m_hist[0];
    norm   = m_level() ^ m_pol;
    for (int i = 0; i < N; i++)
      active[i] = m_mode[i] ? (norm[i] && !m_lastnorm[i]) : norm[i];
    setv = enable ? (active & m_mask) : '0;
    w1c  = (psel && penable && pwrite && paddr == 32'd3) ? pwdata[N-1:0] : '0;
    nxt  = (m_pend & ~w1c) | setv;
    m_trig = setv & ~m_pend;
    m_any  = |(nxt & m_mask);
    m_pend = nxt;
    m_lastnorm = norm;
    if (psel && penable && pwrite) begin
      if (paddr == 32'd0) m_mode = pwdata[N-1:0];
      if (paddr == 32'd1) m_pol  = pwdata[N-1:0];
      if (paddr == 32'd2) m_mask = pwdata[N-1:0];
    end
    for (int i = 0; i < N; i++) begin
      if (synced[i] != m_cond[i]) begin
        m_dcnt[i]++;
        if (m_dcnt[i] >= D) begin
          m_cond[i] = synced[i];
          m_dcnt[i] = 0;
        end
      end else begin
        m_dcnt[i] = 0;
      end
    end
    void'(m_hist.pop_front());
    m_hist.push_back(irq_raw);
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!(psel && !pwrite)) return 32'd0;
    case (paddr)
      32'd0:   return 32'(m_mode);
      32'd1:   return 32'(m_pol);
      32'd2:   return 32'(m_mask);
      32'd3:   return 32'(m_pend);
      32'd4:   return 32'(m_level());
      default: return 32'd0;
    endcase
  endfunction

  // Compare process: advance the model on each edge, check just after it
  always @(posedge pclk) begin
    edge_cnt++;
    model_step();
    #1;
    check("trigger", 32'(irq_trig), 32'(m_trig));
    check("any", 32'(irq_any), 32'(m_any));
    check("prdata", prdata, m_rdata());
    check("pslverr", 32'(pslverr), 32'(psel && penable && paddr > 32'd4));
    check("pready", 32'(pready), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (irq_trig[i] === 1'b1) begin
        trig_cnt[i]++;
        trig_edge[i] = edge_cnt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_err);
    @(negedge pclk); psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge pclk); penable = 1'b1;
    #1;
    check(name, prdata, exp);
    check({name, "_err"}, 32'(pslverr), 32'(exp_err));
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c;
    rst = 1'b1; enable = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_raw = '0;
    tick(3);
    check("rst_trig", 32'(irq_trig), 32'd0);
    check("rst_any", 32'(irq_any), 32'd0);
    rst = 1'b0;
    tick(2);

    // Reset values of every register, and the unmapped-address error
    for (int a = 0; a < 5; a++) apb_read("rst_read", 32'(a), 32'd0, 1'b0);
    apb_read("unmapped", 32'd7, 32'd0, 1'b1);

    // Edge mode, line 0
    apb_write(32'd2, 32'h1);
    apb_write(32'd0, 32'h1);
    irq_raw[0] = 1'b1; t0 = edge_cnt;
    tick(HOLD);
    irq_raw[0] = 1'b0;
    tick(HOLD);
    check("edge_trig_cnt", 32'(trig_cnt[0]), 32'd1);
    check("edge_latency", 32'(trig_edge[0] - t0), 32'(LAT));
    check("edge_any", 32'(irq_any), 32'd1);
    apb_read("edge_pend", 32'd3, 32'h1, 1'b0);
    apb_write(32'd3, 32'h1);
    apb_read("edge_pend_clr", 32'd3, 32'h0, 1'b0);
    check("edge_any_clr", 32'(irq_any), 32'd0);

    // Level mode, active-low line 2 held low
    c = trig_cnt[2];
    apb_write(32'd0, 32'h0);
    apb_write(32'd2, 32'h4);
    apb_write(32'd1, 32'h4);
    tick(3);
    apb_read("lvl_pend", 32'd3, 32'h4, 1'b0);
    check("lvl_trig", 32'(trig_cnt[2] - c), 32'd1);
    check("lvl_any", 32'(irq_any), 32'd1);
    apb_write(32'd3, 32'h4);
    tick(2);
    apb_read("lvl_w1c_active", 32'd3, 32'h4, 1'b0);
    check("lvl_no_retrig", 32'(trig_cnt[2] - c), 32'd1);
    irq_raw[2] = 1'b1;
    tick(HOLD);
    apb_write(32'd3, 32'h4);
    apb_read("lvl_released", 32'd3, 32'h0, 1'b0);
    apb_read("pol_readback", 32'd1, 32'h4, 1'b0);

    // Masked edge on line 1, then unmasking while high
    apb_write(32'd2, 32'h0);
    apb_write(32'd0, 32'h2);
    apb_write(32'd1, 32'h0);
    c = trig_cnt[1];
    irq_raw[1] = 1'b1; tick(HOLD);
    irq_raw[1] = 1'b0; tick(HOLD);
    check("mask_no_trig", 32'(trig_cnt[1] - c), 32'd0);
    apb_read("mask_pend", 32'd3, 32'h0, 1'b0);
    irq_raw[1] = 1'b1; tick(HOLD);
    apb_write(32'd2, 32'h2);
    tick(HOLD);
    check("unmask_high_no_trig", 32'(trig_cnt[1] - c), 32'd0);
    apb_read("unmask_pend", 32'd3, 32'h0, 1'b0);
    irq_raw[1] = 1'b0; tick(HOLD);
    irq_raw[1] = 1'b1; t0 = edge_cnt;
    tick(HOLD);
    check("unmask_edge_trig", 32'(trig_cnt[1] - c), 32'd1);
    check("unmask_latency", 32'(trig_edge[1] - t0), 32'(LAT));
    apb_read("unmask_edge_pend", 32'd3, 32'h2, 1'b0);
    irq_raw[1] = 1'b0;
    apb_write(32'd3, 32'h2);
    apb_read("unmask_pend_clr", 32'd3, 32'h0, 1'b0);

    // Disabled block ignores line 3, then async reset while pending
    enable = 1'b0;
    apb_write(32'd2, 32'h8);
    apb_write(32'd0, 32'h8);
    c = trig_cnt[3];
    irq_raw[3] = 1'b1; tick(HOLD);
    irq_raw[3] = 1'b0; tick(HOLD);
    check("dis_no_trig", 32'(trig_cnt[3] - c), 32'd0);
    apb_read("dis_pend", 32'd3, 32'h0, 1'b0);
    enable = 1'b1;
    irq_raw[3] = 1'b1; tick(HOLD);
    check("en_trig", 32'(trig_cnt[3] - c), 32'd1);
    apb_read("en_pend", 32'd3, 32'h8, 1'b0);
    check("en_any", 32'(irq_any), 32'd1);
    rst = 1'b1;
    psel = 1'b1; pwrite = 1'b0; paddr = 32'd3;
    #1;
    check("async_rst_trig", 32'(irq_trig), 32'd0);
    check("async_rst_any", 32'(irq_any), 32'd0);
    check("async_rst_pend", prdata, 32'd0);
    psel = 1'b0;
    irq_raw = '0;
    tick(2);
    rst = 1'b0;
    tick(2);
    apb_read("post_rst_mask", 32'd2, 32'h0, 1'b0);

`ifdef IRQ_COND_DEBOUNCE_EN
    // Glitch filter: short pulse rejected, long pulse accepted
    apb_write(32'd2, 32'h1);
    apb_write(32'd0, 32'h1);
    c = trig_cnt[0];
    irq_raw[0] = 1'b1; tick(5);
    irq_raw[0] = 1'b0; tick(15);
    check("glitch_no_trig", 32'(trig_cnt[0] - c), 32'd0);
    apb_read("glitch_raw", 32'd4, 32'h0, 1'b0);
    irq_raw[0] = 1'b1; t0 = edge_cnt;
    tick(12);
    apb_read("dbnc_raw", 32'd4, 32'h1, 1'b0);
    check("dbnc_trig", 32'(trig_cnt[0] - c), 32'd1);
    check("dbnc_latency", 32'(trig_edge[0] - t0), 32'd11);
    irq_raw[0] = 1'b0;
    tick(14);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
